dsp48a1_mac_sequencer: RTL and testbench
========================================

// Module: dsp48a1_mac_sequencer
// PURPOSE
//  Sequences one DSP48A1 slice (pipeline registers A/B/D, M, P) through an N-sample multiply-accumulate.
//  Accepts operand beats from an upstream source with a valid/ready handshake.
//  Drives the slice clock enables and OPMODE, aligned to each beat's position in the pipeline.
//  Sits between the sample source and the DSP wrapper; reports completion when P holds the final sum.
// PARAMETERS
//  LEN_W       8             width of burst length / beat counter
//  PIPE_LAT    4             edges from operand-register capture to P-register update (>=2)
//  OPMODE_CLR  8'b0000_0001  OPMODE for first beat: X=M, Z=0 (clears accumulator)
//  OPMODE_ACC  8'b0000_1001  OPMODE for later beats: X=M, Z=P (accumulates)
// PORTS
//  clk        in   1            single clock, rising edge
//  rst        in   1            asynchronous, active-high reset
//  start      in   1            pulse: begin a burst of len beats (honoured only in IDLE)
//  len        in   LEN_W        beat count, sampled with start
//  abort      in   1            cancel current burst, return to IDLE
//  s_valid    in   1            upstream operand beat valid
//  s_ready    out  1            sequencer accepts beat (FEED state only)
//  ce_in      out  1            CE for A/B/D input registers (= s_valid & s_ready)
//  ce_m       out  1            CE for M register
//  ce_p       out  1            CE for P register
//  opmode     out  8            OPMODE to slice, aligned with ce_p
//  busy       out  1            high in FEED or DRAIN
//  res_valid  out  1            1-cycle pulse: P holds final accumulated result
//  done       out  1            1-cycle pulse: burst finished (normal or len==0)
// BEHAVIOUR
//  Reset: state=IDLE; s_ready, ce_in, ce_m, ce_p, busy, res_valid, done all 0; opmode=OPMODE_ACC; tags cleared.
//  States: IDLE, FEED, DRAIN.
//   IDLE : start & len!=0 -> FEED, latch cnt=len. start & len==0 -> done pulse next cycle, res_valid stays 0, remain IDLE.
//   FEED : s_ready=1. Accept = s_valid & s_ready; cnt decrements per accept; accept with cnt==1 -> DRAIN.
//   DRAIN: s_ready=0; when the last-tag reaches final stage -> IDLE.
//   abort (any state, priority over start/accept) -> IDLE next edge, tags flushed, no res_valid, no done.
//   start while busy is ignored; len is not re-sampled.
//  Tag pipeline: PIPE_LAT stages of {v,first,last}; stage 0 loads {accept, first beat of burst, cnt==1}.
//   Shifts every cycle while busy (bubbles carry v=0).
//  Slice control:
//   ce_in = accept. ce_m = busy.
//   ce_p = v of final stage.
//   opmode = first of final stage ? OPMODE_CLR : OPMODE_ACC.
//   P holds during bubbles (ce_p=0).
//  Latency: res_valid and done rise together exactly PIPE_LAT edges after the edge accepting the last beat;
//   both are registered, one cycle wide.
//  Back-to-back: start may be honoured the cycle after done (IDLE); first beat always uses OPMODE_CLR,
//   so no residual sum leaks between bursts.
//  Upstream stalls (s_valid=0) insert bubbles; accumulated sum is unaffected.
//  Reset mid-burst: immediate return to reset values; slice contents are don't-care.
// STRUCTURE
//  Shared package dsp48a1_pkg: state encodings (IDLE/FEED/DRAIN), OPMODE_CLR/OPMODE_ACC defaults.
//  One sub-module dsp_tag_pipe: PIPE_LAT-deep {v,first,last} shift register.
//   Ports: clk, rst, shift_en, flush, tag_in, tag_out; async reset to zero.
//  Top holds FSM, beat counter and output decode.
// TESTING
//  1 len=3, PIPE_LAT=4, beats A*B = 2*3, 4*5, 1*7 back-to-back -> opmode CLR,ACC,ACC on ce_p cycles;
//    P=33; res_valid 4 edges after last accept.
//  2 len=4 with s_valid low 2 cycles between beats -> ce_p low during bubbles; sum correct; done once.
//  3 start with len=0 -> done pulse next cycle, res_valid=0, s_ready never asserted.
//  4 abort after 2 of 5 beats -> IDLE next edge, no res_valid/done; new start len=1 (3*3) -> P=9, CLR opmode used.
//  5 start pulsed during FEED/DRAIN -> ignored, counts unchanged; burst of len=2 completes normally.
//  6 rst asserted mid-DRAIN, async -> all outputs zero same cycle, busy=0; post-reset burst len=2 correct.

Source files
------------

// File: rtl/dsp48a1_pkg.sv
// Shared types and OPMODE defaults for the DSP48A1 MAC sequencer and its tag pipeline.
// Tags travel alongside each operand beat so slice controls line up with the P stage.
package dsp48a1_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FEED  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    localparam logic [7:0] OPMODE_CLR_DEF = 8'b0000_0001;
    localparam logic [7:0] OPMODE_ACC_DEF = 8'b0000_1001;

    typedef struct packed {
        logic v;
        logic first;
        logic last;
    } tag_t;

    // Qualifier bits are only meaningful on a real beat, so gate them with v.
    function automatic tag_t make_tag(input logic accept, input logic first, input logic last);
        tag_t t;
        t.v     = accept;
        t.first = accept & first;
        t.last  = accept & last;
        return t;
    endfunction

endpackage

// File: rtl/dsp48a1_mac_sequencer_if.sv
// Control/handshake bundle between the sample source, the sequencer and the DSP slice.
// master = source/controller side, slave = sequencer side.
interface dsp48a1_mac_sequencer_if #(
    parameter int LEN_W = 8
);
    logic             start;
    logic [LEN_W-1:0] len;
    logic             abort;
    logic             s_valid;
    logic             s_ready;
    logic             ce_in;
    logic             ce_m;
    logic             ce_p;
    logic [7:0]       opmode;
    logic             busy;
    logic             res_valid;
    logic             done;

    modport master (
        output start, len, abort, s_valid,
        input  s_ready, ce_in, ce_m, ce_p, opmode, busy, res_valid, done
    );

    modport slave (
        input  start, len, abort, s_valid,
        output s_ready, ce_in, ce_m, ce_p, opmode, busy, res_valid, done
    );
endinterface

// File: rtl/dsp_tag_pipe.sv
// PIPE_LAT-deep {v,first,last} shift register mirroring beats through the slice.
// Shifts only when enabled; flush clears every stage synchronously.
module dsp_tag_pipe
    import dsp48a1_pkg::*;
#(
    parameter int PIPE_LAT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic shift_en,
    input  logic flush,
    input  tag_t tag_in,
    output tag_t tag_out
);

    tag_t stage [PIPE_LAT];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < PIPE_LAT; i++) stage[i] <= '0;
        end else if (flush) begin
            for (int i = 0; i < PIPE_LAT; i++) stage[i] <= '0;
        end else if (shift_en) begin
            stage[0] <= tag_in;
            for (int i = 1; i < PIPE_LAT; i++) stage[i] <= stage[i-1];
        end
    end

    assign tag_out = stage[PIPE_LAT-1];

endmodule

// File: rtl/dsp48a1_mac_sequencer.sv
// Drives DSP48A1 CEs/OPMODE for an N-beat MAC; result/done PIPE_LAT edges after the last accept.
// Upstream backpressure: s_ready only in FEED; stalls become bubbles that leave P untouched.
module dsp48a1_mac_sequencer
    import dsp48a1_pkg::*;
#(
    parameter int         LEN_W      = 8,
    parameter int         PIPE_LAT   = 4,
    parameter logic [7:0] OPMODE_CLR = OPMODE_CLR_DEF,
    parameter logic [7:0] OPMODE_ACC = OPMODE_ACC_DEF
) (
    input  logic                      clk,
    input  logic                      rst,
    dsp48a1_mac_sequencer_if.slave    bus
);

    localparam logic [LEN_W-1:0] CNT_ONE = {{(LEN_W-1){1'b0}}, 1'b1};

    state_t           state, state_nxt;
    logic [LEN_W-1:0] cnt;
    logic             first_beat;
    logic             busy;
    logic             accept;
    logic             final_last;
    logic             start_ok;
    logic             start_zero;
    logic             res_valid_q;
    logic             done_q;
    tag_t             tag_in;
    tag_t             tag_out;

    assign busy       = (state != ST_IDLE);
    assign accept     = bus.s_valid & (state == ST_FEED);
    assign final_last = tag_out.v & tag_out.last;
    assign start_ok   = (state == ST_IDLE) & bus.start & (bus.len != '0);
    assign start_zero = (state == ST_IDLE) & bus.start & (bus.len == '0);
    assign tag_in     = make_tag(accept, first_beat, cnt == CNT_ONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (bus.abort) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:  if (start_ok) state_nxt = ST_FEED;
                ST_FEED:  if (accept && cnt == CNT_ONE) state_nxt = ST_DRAIN;
                ST_DRAIN: if (final_last) state_nxt = ST_IDLE;
                default:  state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt        <= '0;
            first_beat <= 1'b0;
        end else if (bus.abort) begin
            cnt        <= '0;
            first_beat <= 1'b0;
        end else if (start_ok) begin
            cnt        <= bus.len;
            first_beat <= 1'b1;
        end else if (accept) begin
            cnt        <= cnt - CNT_ONE;
            first_beat <= 1'b0;
        end
    end

    // Both pulses fire on the edge where P absorbs the final product.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_valid_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            res_valid_q <= ~bus.abort & final_last & (state == ST_DRAIN);
            done_q      <= ~bus.abort & ((final_last & (state == ST_DRAIN)) | start_zero);
        end
    end

    dsp_tag_pipe #(
        .PIPE_LAT (PIPE_LAT)
    ) u_tag_pipe (
        .clk      (clk),
        .rst      (rst),
        .shift_en (busy),
        .flush    (bus.abort),
        .tag_in   (tag_in),
        .tag_out  (tag_out)
    );

    assign bus.s_ready   = (state == ST_FEED);
    assign bus.ce_in     = accept;
    assign bus.ce_m      = busy;
    assign bus.ce_p      = tag_out.v;
    assign bus.opmode    = tag_out.first ? OPMODE_CLR : OPMODE_ACC;
    assign bus.busy      = busy;
    assign bus.res_valid = res_valid_q;
    assign bus.done      = done_q;

endmodule

// File: tb/tb_dsp48a1_mac_sequencer.sv
// Directed + randomized bench for dsp48a1_mac_sequencer against a beat-queue model of the slice.
module tb_dsp48a1_mac_sequencer;

    localparam int         PIPE_LAT = 4;
    localparam logic [7:0] CLR      = 8'b0000_0001;
    localparam logic [7:0] ACC      = 8'b0000_1001;

    logic clk = 1'b0;
    logic rst = 1'b0;

    dsp48a1_mac_sequencer_if #(.LEN_W(8)) bus();

    dsp48a1_mac_sequencer #(
        .LEN_W    (8),
        .PIPE_LAT (PIPE_LAT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference: every accepted beat's product queues up; each ce_p consumes one,
    // restarting the sum on CLR and adding on ACC.
    logic [7:0]  cur_a = 8'd0, cur_b = 8'd0;
    int unsigned prodq[$];
    int          accq[$];
    logic [7:0]  opm_log[$];
    int unsigned p_model = 0, p_at_rv = 0, prod = 0, exp_sum = 0;
    int          ce_p_cnt = 0, rv_cnt = 0, done_cnt = 0, ready_cnt = 0;
    int          spur_cnt = 0, lat_err = 0, last_acc_edge = 0, rv_edge = 0, acc_e = 0;

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.s_valid && bus.s_ready) begin
                prodq.push_back(32'(cur_a) * 32'(cur_b));
                accq.push_back(cyc + 1);
                last_acc_edge = cyc + 1;
            end
            if (bus.s_ready) ready_cnt++;
            if (bus.ce_p) begin
                ce_p_cnt++;
                opm_log.push_back(bus.opmode);
                if (prodq.size() == 0) begin
                    spur_cnt++;
                end else begin
                    prod  = prodq.pop_front();
                    acc_e = accq.pop_front();
                    if (cyc != acc_e + PIPE_LAT - 1) lat_err++;
                    p_model = (bus.opmode == CLR) ? prod : p_model + prod;
                end
            end
            if (bus.res_valid) begin
                rv_cnt++;
                rv_edge = cyc;
                p_at_rv = p_model;
            end
            if (bus.done) done_cnt++;
            if (bus.abort) begin
                prodq.delete();
                accq.delete();
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int c_cep, c_rv, c_done, c_lat, c_spur;

    task automatic start_burst(input logic [7:0] n);
        bus.start = 1'b1;
        bus.len   = n;
        opm_log.delete();
        exp_sum = 0;
        c_cep = ce_p_cnt; c_rv = rv_cnt; c_done = done_cnt; c_lat = lat_err; c_spur = spur_cnt;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic feed_beat(input logic [7:0] a, input logic [7:0] b, input int stall);
        bus.s_valid = 1'b0;
        for (int i = 0; i < stall; i++) tick();
        cur_a = a;
        cur_b = b;
        bus.s_valid = 1'b1;
        for (int g = 0; g < 50 && bus.s_ready !== 1'b1; g++) tick();
        exp_sum += 32'(a) * 32'(b);
        tick();
    endtask

    task automatic finish_burst(input string name, input int n);
        bit ok;
        bit seq_ok;
        ok = 1'b0;
        bus.s_valid = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (bus.done === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        chk({name, "_done_seen"}, 32'(ok), 32'd1);
        chk({name, "_rv_with_done"}, 32'(bus.res_valid), 32'd1);
        tick();
        chk({name, "_sum"}, p_at_rv, exp_sum);
        chk({name, "_latency"}, rv_edge - last_acc_edge, PIPE_LAT);
        chk({name, "_ce_p_count"}, ce_p_cnt - c_cep, n);
        chk({name, "_ce_p_timing"}, lat_err - c_lat, 0);
        chk({name, "_spurious_ce_p"}, spur_cnt - c_spur, 0);
        seq_ok = (opm_log.size() == n);
        for (int i = 0; i < opm_log.size(); i++)
            if (opm_log[i] !== ((i == 0) ? CLR : ACC)) seq_ok = 1'b0;
        chk({name, "_opmode_seq"}, 32'(seq_ok), 32'd1);
        for (int i = 0; i < 3; i++) tick();
        chk({name, "_done_once"}, done_cnt - c_done, 1);
        chk({name, "_rv_once"}, rv_cnt - c_rv, 1);
        chk({name, "_idle_after"}, 32'(bus.busy), 32'd0);
    endtask

    int rn;

    initial begin
        bus.start = 1'b0; bus.len = 8'd0; bus.abort = 1'b0; bus.s_valid = 1'b0;
        #1 rst = 1'b1;
        #2;
        chk("rst_s_ready", 32'(bus.s_ready), 0);
        chk("rst_ce_in", 32'(bus.ce_in), 0);
        chk("rst_ce_m", 32'(bus.ce_m), 0);
        chk("rst_ce_p", 32'(bus.ce_p), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_res_valid", 32'(bus.res_valid), 0);
        chk("rst_done", 32'(bus.done), 0);
        chk("rst_opmode", 32'(bus.opmode), 32'(ACC));
        tick(); tick();
        rst = 1'b0;
        tick();

        // Back-to-back 2*3 + 4*5 + 1*7
        start_burst(8'd3);
        chk("t1_s_ready", 32'(bus.s_ready), 1);
        feed_beat(8'd2, 8'd3, 0);
        feed_beat(8'd4, 8'd5, 0);
        feed_beat(8'd1, 8'd7, 0);
        finish_burst("t1", 3);
        chk("t1_p33", p_at_rv, 33);

        // Two-cycle stalls between beats
        start_burst(8'd4);
        for (int i = 0; i < 4; i++)
            feed_beat(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), (i == 0) ? 0 : 2);
        finish_burst("t2", 4);

        // Zero-length burst
        rn = ready_cnt;
        c_rv = rv_cnt;
        bus.start = 1'b1; bus.len = 8'd0;
        tick();
        bus.start = 1'b0;
        chk("t3_done_pulse", 32'(bus.done), 1);
        chk("t3_no_rv", 32'(bus.res_valid), 0);
        chk("t3_busy", 32'(bus.busy), 0);
        tick();
        chk("t3_done_width", 32'(bus.done), 0);
        tick();
        chk("t3_no_ready", ready_cnt - rn, 0);
        chk("t3_no_rv_cnt", rv_cnt - c_rv, 0);

        // Abort after 2 of 5, then a fresh 3*3
        start_burst(8'd5);
        feed_beat(8'($urandom_range(1, 255)), 8'($urandom_range(1, 255)), 0);
        feed_beat(8'($urandom_range(1, 255)), 8'($urandom_range(1, 255)), 0);
        bus.s_valid = 1'b0;
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        chk("t4_abort_busy", 32'(bus.busy), 0);
        chk("t4_abort_ready", 32'(bus.s_ready), 0);
        for (int i = 0; i < 8; i++) tick();
        chk("t4_abort_no_ce_p", ce_p_cnt - c_cep, 0);
        chk("t4_abort_no_rv", rv_cnt - c_rv, 0);
        chk("t4_abort_no_done", done_cnt - c_done, 0);
        start_burst(8'd1);
        feed_beat(8'd3, 8'd3, 0);
        finish_burst("t4", 1);
        chk("t4_p9", p_at_rv, 9);

        // Start pulses while busy are ignored
        start_burst(8'd2);
        feed_beat(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 0);
        bus.start = 1'b1; bus.len = 8'd7;
        feed_beat(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 0);
        bus.start = 1'b0;
        bus.s_valid = 1'b0;
        tick();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        finish_burst("t5", 2);

        // Async reset mid-DRAIN
        start_burst(8'd2);
        feed_beat(8'd9, 8'd9, 0);
        feed_beat(8'd8, 8'd8, 0);
        bus.s_valid = 1'b0;
        tick(); tick();
        #2 rst = 1'b1;
        #1;
        chk("t6_busy", 32'(bus.busy), 0);
        chk("t6_ready", 32'(bus.s_ready), 0);
        chk("t6_ce_m", 32'(bus.ce_m), 0);
        chk("t6_ce_p", 32'(bus.ce_p), 0);
        chk("t6_rv", 32'(bus.res_valid), 0);
        chk("t6_done", 32'(bus.done), 0);
        prodq.delete();
        accq.delete();
        tick();
        rst = 1'b0;
        tick();
        start_burst(8'd2);
        feed_beat(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 0);
        feed_beat(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1);
        finish_burst("t6", 2);

        // Random bursts with random stalls
        for (int k = 0; k < 4; k++) begin
            int n;
            n = $urandom_range(1, 6);
            start_burst(8'(n));
            for (int i = 0; i < n; i++)
                feed_beat(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), $urandom_range(0, 2));
            finish_burst($sformatf("rnd%0d", k), n);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
